rou_axi_rd_splitter: RTL and testbench



---
 rtl/rou_axi_rd_splitter.sv | 109 ++++++++++
 tb/tb_rou_axi_rd_splitter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rou_axi_rd_splitter.sv
// Splits one byte-addressed read request into the minimal sequence of INCR
// AR bursts of 16-byte beats, bounded by MAXBEATS and BOUNDARY crossings.
module rou_axi_rd_splitter #(
  parameter int ADWID    = 32,
  parameter int MAXBEATS = 16,
  parameter int BOUNDARY = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADWID-1:0] req_addr,
  input  logic [19:0]      req_bytes,
  input  logic [3:0]       req_id,
  output logic             arvalid,
  input  logic             arready,
  output logic [ADWID-1:0] araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic [3:0]       arid,
  output logic             ar_first,
  output logic             ar_last,
  output logic             busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam int BND_BEATS = BOUNDARY / 16;

  logic [0:0]       state_q, state_d;
  logic [ADWID-1:0] cur_q, cur_d;
  logic [16:0]      rem_q, rem_d;
  logic [3:0]       id_q, id_d;
  logic             first_q, first_d;

  logic [31:0]      tobound;
  logic [16:0]      len;
  logic             is_last;

  // Beats left before the next boundary, counted from the aligned beat address.
  assign tobound = 32'(BND_BEATS) - 32'((cur_q & ADWID'(BOUNDARY - 1)) >> 4);

  always_comb begin
    len = rem_q;
    if (len > 17'(MAXBEATS)) len = 17'(MAXBEATS);
    if ({15'd0, len} > tobound) len = tobound[16:0];
  end

  assign is_last = (len == rem_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    id_d    = id_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_bytes != '0) begin
          cur_d   = req_addr;
          // Beat count survives address wrap because only the low 17 bits matter.
          rem_d   = 17'((req_addr + ADWID'(req_bytes) - ADWID'(1)) >> 4)
                  - 17'(req_addr >> 4) + 17'd1;
          id_d    = req_id;
          first_d = 1'b1;
          state_d = ISSUE;
        end
      end
      default: begin
        if (arready) begin
          cur_d   = (cur_q & ~ADWID'(15)) + (ADWID'(len) << 4);
          rem_d   = rem_q - len;
          first_d = 1'b0;
          if (is_last) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      first_q <= first_d;
    end
  end

  // AR fields are forced to zero outside ISSUE so idle outputs match reset.
  assign req_ready = (state_q == IDLE);
  assign arvalid   = (state_q == ISSUE);
  assign busy      = arvalid;
  assign araddr    = arvalid ? cur_q : '0;
  assign arlen     = arvalid ? 8'(len - 17'd1) : 8'd0;
  assign arid      = arvalid ? id_q : 4'd0;
  assign ar_first  = arvalid & first_q;
  assign ar_last   = arvalid & is_last;
  assign arsize    = 3'd4;
  assign arburst   = 2'd1;

endmodule

// File: tb/tb_rou_axi_rd_splitter.sv
// Bench for rou_axi_rd_splitter: directed vector table, reset abort sequence
// and randomized requests checked against a beat-walking reference model.
module tb_rou_axi_rd_splitter;

  localparam int ADWID    = 32;
  localparam int MAXBEATS = 16;
  localparam int BOUNDARY = 4096;
  localparam int BB       = BOUNDARY / 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [ADWID-1:0] req_addr = '0;
  logic [19:0]      req_bytes = '0;
  logic [3:0]       req_id = '0;
  logic             arvalid;
  logic             arready = 1'b0;
  logic [ADWID-1:0] araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic [3:0]       arid;
  logic             ar_first;
  logic             ar_last;
  logic             busy;

  always #5 clk = ~clk;

  rou_axi_rd_splitter #(
    .ADWID(ADWID), .MAXBEATS(MAXBEATS), .BOUNDARY(BOUNDARY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_bytes(req_bytes), .req_id(req_id),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .ar_first(ar_first), .ar_last(ar_last), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic        first;
    logic        last;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    int          bytes;
    logic [3:0]  id;
    int          mode;     // 0 always ready, 1 random ready, 2 stall 2nd burst 5 cycles
    int          exp_n;
    logic [31:0] f_addr;
    int          f_len;
    logic [31:0] l_addr;
    int          l_len;
  } vec_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  burst_t exp_q[$];
  burst_t obs_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Walks the request beat by beat in unbounded arithmetic, cutting greedily.
  function automatic void model(input logic [31:0] a, input int b);
    longint unsigned bi, n, room, len;
    burst_t bt;
    exp_q.delete();
    if (b == 0) return;
    bi = {32'd0, a} >> 4;
    n  = (({32'd0, a} + 64'(b) - 64'd1) >> 4) - bi + 64'd1;
    while (n > 0) begin
      room = 64'(BB) - (bi % 64'(BB));
      len  = n;
      if (len > 64'(MAXBEATS)) len = 64'(MAXBEATS);
      if (len > room) len = room;
      bt.addr  = (exp_q.size() == 0) ? a : 32'(bi << 4);
      bt.len   = int'(len);
      bt.first = (exp_q.size() == 0);
      bt.last  = (len == n);
      exp_q.push_back(bt);
      bi += len;
      n  -= len;
    end
  endfunction

  task automatic run_req(input logic [31:0] a, input int b, input logic [3:0] id,
                         input int mode, input string tag);
    int     k = 0;
    int     stall_left = 5;
    int     stalled = 0;
    int     cyc = 0;
    logic   hold = 1'b0;
    logic [31:0] h_addr = '0;
    logic [7:0]  h_len = '0;
    burst_t bt;
    model(a, b);
    obs_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_bytes = 20'(b); req_id = id;
    arready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk({tag, " req_ready_idle"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_bytes = 20'($urandom); req_id = 4'($urandom);
    if (exp_q.size() == 0) begin
      repeat (3) begin
        @(negedge clk);
        chk({tag, " empty_arvalid"}, 64'(arvalid), 64'd0);
        chk({tag, " empty_req_ready"}, 64'(req_ready), 64'd1);
      end
      $display("req %s addr=0x%08h bytes=%0d bursts=0", tag, a, b);
      return;
    end
    @(negedge clk);
    chk({tag, " first_latency"}, 64'(arvalid), 64'd1);
    forever begin
      if (hold) begin
        chk({tag, " hold_arvalid"}, 64'(arvalid), 64'd1);
        chk({tag, " hold_araddr"}, 64'(araddr), 64'(h_addr));
        chk({tag, " hold_arlen"}, 64'(arlen), 64'(h_len));
      end
      hold   = arvalid && !arready;
      h_addr = araddr;
      h_len  = arlen;
      if (hold) stalled++;
      if (!arvalid) begin
        chk({tag, " early_idle"}, 64'(k), 64'(exp_q.size()));
        break;
      end
      if (arready) begin
        bt.addr = araddr; bt.len = int'(arlen) + 1; bt.first = ar_first; bt.last = ar_last;
        obs_q.push_back(bt);
        chk({tag, " araddr"}, 64'(araddr), 64'(exp_q[k].addr));
        chk({tag, " arlen"}, 64'(arlen), 64'(exp_q[k].len - 1));
        chk({tag, " arid"}, 64'(arid), 64'(id));
        chk({tag, " ar_first"}, 64'(ar_first), 64'(exp_q[k].first));
        chk({tag, " ar_last"}, 64'(ar_last), 64'(exp_q[k].last));
        chk({tag, " arsize"}, 64'(arsize), 64'd4);
        chk({tag, " arburst"}, 64'(arburst), 64'd1);
        k++;
        if (k == exp_q.size()) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk({tag, " done_req_ready"}, 64'(req_ready), 64'd1);
          chk({tag, " done_arvalid"}, 64'(arvalid), 64'd0);
          chk({tag, " done_busy"}, 64'(busy), 64'd0);
          break;
        end
      end
      cyc++;
      if (cyc > 5000) begin
        chk({tag, " timeout"}, 64'(k), 64'(exp_q.size()));
        break;
      end
      @(posedge clk); #1;
      if (mode == 1) arready = 1'($urandom_range(0, 1));
      else if (mode == 2 && k == 1 && stall_left > 0) begin
        arready = 1'b0;
        stall_left--;
      end else arready = 1'b1;
      @(negedge clk);
    end
    if (mode == 2) chk({tag, " stall_cycles"}, 64'(stalled), 64'd5);
    $display("req %s addr=0x%08h bytes=%0d id=%0d bursts=%0d", tag, a, b, id, obs_q.size());
  endtask

  initial begin
    vec_t vecs[8];
    int   cnt;
    int   cyc;
    logic [31:0] r;
    logic [31:0] a;
    int   b;

    vecs[0] = '{32'h100,      1024, 4'h3, 0, 4,  32'h100,      15, 32'h400,  15};
    vecs[1] = '{32'hFF0,      48,   4'h7, 0, 2,  32'hFF0,      0,  32'h1000, 1};
    vecs[2] = '{32'h1008,     16,   4'h9, 0, 1,  32'h1008,     1,  32'h1008, 1};
    vecs[3] = '{32'h100,      1024, 4'h3, 2, 4,  32'h100,      15, 32'h400,  15};
    vecs[4] = '{32'h0,        0,    4'h1, 0, 0,  32'h0,        0,  32'h0,    0};
    vecs[5] = '{32'h1008,     16,   4'h2, 0, 1,  32'h1008,     1,  32'h1008, 1};
    vecs[6] = '{32'hFFFFFFF8, 32,   4'hA, 0, 2,  32'hFFFFFFF8, 0,  32'h0,    1};
    vecs[7] = '{32'hFF8,      4096, 4'hC, 1, 17, 32'hFF8,      0,  32'h1F00, 15};

    repeat (2) @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst arvalid", 64'(arvalid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst araddr", 64'(araddr), 64'd0);
    chk("rst arlen", 64'(arlen), 64'd0);
    chk("rst arid", 64'(arid), 64'd0);
    chk("rst ar_first", 64'(ar_first), 64'd0);
    chk("rst ar_last", 64'(ar_last), 64'd0);
    chk("rst arsize", 64'(arsize), 64'd4);
    chk("rst arburst", 64'(arburst), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_req(vecs[i].addr, vecs[i].bytes, vecs[i].id, vecs[i].mode, tag);
      chk({tag, " n_bursts"}, 64'(obs_q.size()), 64'(vecs[i].exp_n));
      if (obs_q.size() > 0 && vecs[i].exp_n > 0) begin
        chk({tag, " tbl_first_addr"}, 64'(obs_q[0].addr), 64'(vecs[i].f_addr));
        chk({tag, " tbl_first_len"}, 64'(obs_q[0].len - 1), 64'(vecs[i].f_len));
        chk({tag, " tbl_last_addr"}, 64'(obs_q[$].addr), 64'(vecs[i].l_addr));
        chk({tag, " tbl_last_len"}, 64'(obs_q[$].len - 1), 64'(vecs[i].l_len));
      end
    end

    // Reset in the middle of a multi-burst request.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h100; req_bytes = 20'd1024; req_id = 4'h5; arready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 2 && cyc < 50) begin
      @(negedge clk);
      if (arvalid && arready) cnt++;
      cyc++;
    end
    chk("rstmid two_bursts", 64'(cnt), 64'd2);
    @(posedge clk); #1;
    chk("rstmid busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid arvalid", 64'(arvalid), 64'd0);
    chk("rstmid req_ready", 64'(req_ready), 64'd1);
    chk("rstmid busy", 64'(busy), 64'd0);
    chk("rstmid araddr", 64'(araddr), 64'd0);
    chk("rstmid arlen", 64'(arlen), 64'd0);
    chk("rstmid ar_first", 64'(ar_first), 64'd0);
    $display("req rstmid addr=0x00000100 bytes=1024 aborted after %0d bursts", cnt);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_req(32'h2000, 16, 4'h6, 0, "postrst");
    chk("postrst n_bursts", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) begin
      chk("postrst araddr", 64'(obs_q[0].addr), 64'h2000);
      chk("postrst arlen", 64'(obs_q[0].len - 1), 64'd0);
      chk("postrst ar_first", 64'(obs_q[0].first), 64'd1);
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if ($urandom_range(0, 2) == 0) a = {r[31:12], 4'hF, 8'($urandom)};
      else a = r;
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3000));
      run_req(a, b, 4'($urandom), 1, $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d n_bursts", i), 64'(obs_q.size()), 64'(exp_q.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
